// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes and FSM state type for the data load-store unit
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_formatter.sv
// rtl/lsu_load_formatter.sv - selects and extends the addressed byte/half of a loaded word
module lsu_load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by address offset, then sign/zero extension by size code;
    // unknown size codes fall through to the full word.
    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            LDST_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: result_o = {24'h0, byte_sel};
            LDST_H:  result_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: result_o = {16'h0, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// rtl/data_lsu.sv - load-store unit: one aligned memory access per core request, stall and watchdog
module data_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_t        state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       core_rd_q, core_rd_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        st_be;
    logic [31:0]       st_wd;
    logic [31:0]       load_fmt;
    logic              expire;

    lsu_load_formatter u_fmt (
        .word_i   (mem_rd_i),
        .size_i   (size_q),
        .off_i    (off_q),
        .result_o (load_fmt)
    );

    // Store lane placement: data replicated across lanes, byte enables pick the target lanes.
    always_comb begin
        case (core_size_i)
            LDST_B: begin
                st_be = 4'b0001 << core_addr_i[1:0];
                st_wd = {4{core_wd_i[7:0]}};
            end
            LDST_H: begin
                st_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{core_wd_i[15:0]}};
            end
            default: begin
                st_be = 4'b1111;
                st_wd = core_wd_i;
            end
        endcase
    end

    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Transaction FSM: latch the request in IDLE, wait for ready (or watchdog) in REQ,
    // give the core one unstalled cycle in DONE.
    always_comb begin
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        size_d     = size_q;
        off_d      = off_q;
        core_rd_d  = core_rd_q;
        fault_d    = 1'b0;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    state_d    = REQ;
                    mem_we_d   = core_we_i;
                    mem_addr_d = {core_addr_i[31:2], 2'b00};
                    mem_be_d   = core_we_i ? st_be : 4'b1111;
                    mem_wd_d   = core_we_i ? st_wd : 32'h0;
                    size_d     = core_size_i;
                    off_d      = core_addr_i[1:0];
                    cnt_d      = '0;
                end
            end
            REQ: begin
                if (mem_ready_i) begin
                    if (!mem_we_q) begin
                        core_rd_d = load_fmt;
                    end
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (expire) begin
                    core_rd_d = 32'h0;
                    fault_d   = 1'b1;
                    state_d   = DONE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'h0;
            mem_addr_q <= 32'h0;
            mem_wd_q   <= 32'h0;
            size_q     <= 3'h0;
            off_q      <= 2'h0;
            core_rd_q  <= 32'h0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            size_q     <= size_d;
            off_q      <= off_d;
            core_rd_q  <= core_rd_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    assign core_stall_o = core_req_i & (state_q != DONE);
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wd_o     = mem_wd_q;
    assign core_rd_o    = core_rd_q;
    assign core_fault_o = fault_q;

endmodule

// File: tb/tb_data_lsu.sv
// tb/tb_data_lsu.sv - directed scoreboard bench for data_lsu (no-watchdog and watchdog instances)
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        rdy0 = 1'b0, rdy1 = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  size = 3'd0;
    logic [31:0] addr = 32'h0, wd = 32'h0, mrd = 32'h0;

    logic [31:0] rd0, rd1, maddr0, maddr1, mwd0, mwd1;
    logic        stall0, stall1, fault0, fault1, mreq0, mreq1, mwe0, mwe1;
    logic [3:0]  be0, be1;

    bit          sel = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    wire [31:0] s_rd    = sel ? rd1    : rd0;
    wire        s_stall = sel ? stall1 : stall0;
    wire        s_fault = sel ? fault1 : fault0;
    wire        s_mreq  = sel ? mreq1  : mreq0;
    wire        s_mwe   = sel ? mwe1   : mwe0;
    wire [3:0]  s_be    = sel ? be1    : be0;
    wire [31:0] s_addr  = sel ? maddr1 : maddr0;
    wire [31:0] s_wd    = sel ? mwd1   : mwd0;

    data_lsu #(.TIMEOUT_CYCLES(0), .CNT_W(8)) dut0 (
        .clk_i(clk), .rst_i(rst), .core_req_i(req0), .core_we_i(we), .core_size_i(size),
        .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd0), .core_stall_o(stall0),
        .core_fault_o(fault0), .mem_req_o(mreq0), .mem_we_o(mwe0), .mem_be_o(be0),
        .mem_addr_o(maddr0), .mem_wd_o(mwd0), .mem_rd_i(mrd), .mem_ready_i(rdy0)
    );

    data_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .core_req_i(req1), .core_we_i(we), .core_size_i(size),
        .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd1), .core_stall_o(stall1),
        .core_fault_o(fault1), .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_be_o(be1),
        .mem_addr_o(maddr1), .mem_wd_o(mwd1), .mem_rd_i(mrd), .mem_ready_i(rdy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One core access; delay < 0 means memory never answers (watchdog instance only).
    task automatic access(input bit s, input bit w, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] word,
                          input int delay, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input bit exp_fault, input string tag);
        int stall_n;
        int req_n;
        int faults;
        logic [31:0] exp_addr;
        logic [31:0] got;
        exp_addr = {a[31:2], 2'b00};
        exp_q.push_back(exp_rd);
        @(negedge clk);
        sel = s;
        we = w; size = sz; addr = a; wd = d;
        if (s) req1 = 1'b1; else req0 = 1'b1;
        stall_n = 0; req_n = 0; faults = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            if (s_fault) faults++;
            if (!s_stall) break;
            stall_n++;
            if (s_mreq) begin
                chk({tag, ".addr"}, s_addr, exp_addr);
                chk({tag, ".be"},   {28'h0, s_be}, {28'h0, exp_be});
                chk({tag, ".wd"},   s_wd, exp_wd);
                chk({tag, ".we"},   {31'h0, s_mwe}, {31'h0, w});
                if (req_n == delay) begin
                    mrd = word;
                    if (s) rdy1 = 1'b1; else rdy0 = 1'b1;
                end
                req_n++;
            end
            @(negedge clk);
            rdy0 = 1'b0; rdy1 = 1'b0; mrd = 32'h0;
        end
        chk({tag, ".stall_cycles"}, stall_n, (delay >= 0) ? delay + 2 : 5);
        chk({tag, ".req_cycles"}, req_n, (delay >= 0) ? delay + 1 : 4);
        chk({tag, ".faults"}, faults, {31'h0, exp_fault});
        got = exp_q.pop_front();
        chk({tag, ".rd"}, s_rd, got);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk); #1;
        chk({tag, ".idle_mreq"}, {31'h0, s_mreq}, 32'h0);
        chk({tag, ".idle_fault"}, {31'h0, s_fault}, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst.rd0", rd0, 32'h0);
        chk("rst.mreq0", {31'h0, mreq0}, 32'h0);
        chk("rst.be0", {28'h0, be0}, 32'h0);
        chk("rst.addr0", maddr0, 32'h0);
        chk("rst.wd0", mwd0, 32'h0);
        chk("rst.fault1", {31'h0, fault1}, 32'h0);
        chk("rst.rd1", rd1, 32'h0);
        rst = 1'b1;

        // sel, we, size, addr, wd, memword, delay, be, wd_exp, rd_exp, fault
        access(0, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0, "lw");
        access(0, 0, 3'd0, 32'h103, 32'h0, 32'h80FF7F01, 0, 4'hF, 32'h0, 32'hFFFFFF80, 0, "lb");
        access(0, 0, 3'd4, 32'h103, 32'h0, 32'h80FF7F01, 0, 4'hF, 32'h0, 32'h00000080, 0, "lbu");
        access(0, 0, 3'd5, 32'h102, 32'h0, 32'h80FF7F01, 0, 4'hF, 32'h0, 32'h000080FF, 0, "lhu");
        access(0, 0, 3'd1, 32'h102, 32'h0, 32'h80FF7F01, 0, 4'hF, 32'h0, 32'hFFFF80FF, 0, "lh_hi");
        access(0, 0, 3'd1, 32'h100, 32'h0, 32'h80FF7F01, 0, 4'hF, 32'h0, 32'h00007F01, 0, "lh_lo");
        access(0, 0, 3'd0, 32'h101, 32'h0, 32'h80FF7F01, 0, 4'hF, 32'h0, 32'h0000007F, 0, "lb_pos");
        access(0, 0, 3'd6, 32'h102, 32'h0, 32'h13579BDF, 0, 4'hF, 32'h0, 32'h13579BDF, 0, "l6");
        access(0, 1, 3'd0, 32'h201, 32'hAB, 32'h0, 0, 4'b0010, 32'hABABABAB, 32'h13579BDF, 0, "sb");
        access(0, 1, 3'd1, 32'h202, 32'h1234, 32'h0, 0, 4'b1100, 32'h12341234, 32'h13579BDF, 0, "sh_hi");
        access(0, 1, 3'd1, 32'h201, 32'h5678, 32'h0, 1, 4'b0011, 32'h56785678, 32'h13579BDF, 0, "sh_odd");
        access(0, 1, 3'd3, 32'h303, 32'hCAFEF00D, 32'h0, 0, 4'hF, 32'hCAFEF00D, 32'h13579BDF, 0, "s3");
        access(0, 0, 3'd2, 32'h400, 32'h0, 32'h12345678, 5, 4'hF, 32'h0, 32'h12345678, 0, "lw_slow");

        access(1, 0, 3'd2, 32'h500, 32'h0, 32'hA5A5A5A5, 1, 4'hF, 32'h0, 32'hA5A5A5A5, 0, "wd_lw");
        access(1, 0, 3'd2, 32'h504, 32'h0, 32'h0BADF00D, 3, 4'hF, 32'h0, 32'h0BADF00D, 0, "wd_edge");
        access(1, 0, 3'd2, 32'h508, 32'h0, 32'hFFFFFFFF, -1, 4'hF, 32'h0, 32'h0, 1, "wd_expire");
        access(1, 0, 3'd4, 32'h50A, 32'h0, 32'h00C30000, 0, 4'hF, 32'h0, 32'h000000C3, 0, "wd_after");

        // Reset while a store is in REQ: request must drop at once, enables must not leak.
        @(negedge clk);
        sel = 0; we = 1'b1; size = 3'd0; addr = 32'h201; wd = 32'hAB; req0 = 1'b1;
        @(negedge clk); #1;
        chk("rstreq.mreq_before", {31'h0, mreq0}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rstreq.mreq", {31'h0, mreq0}, 32'h0);
        chk("rstreq.be", {28'h0, be0}, 32'h0);
        chk("rstreq.rd", rd0, 32'h0);
        @(negedge clk);
        req0 = 1'b0;
        rst = 1'b1;
        access(0, 0, 3'd2, 32'h600, 32'h0, 32'h600DCAFE, 0, 4'hF, 32'h0, 32'h600DCAFE, 0, "post_rst");

        chk("scoreboard.empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
